// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer.
// Each bit is sampled at its centre: the start bit is confirmed half a bit
// after the falling edge, and each later bit is sampled one full bit after
// the previous sample. dout_rdy and frame_err are registered one-cycle pulses.
//
// Handshake: no backpressure. dout_rdy is a one-cycle valid strobe with no
// ready. The consumer must capture dout in that cycle. dout then holds until
// the next good frame overwrites it.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_rdy,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [2:0]           idx, idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic [DATA_BITS-1:0] dout_nx;
    logic                 rdy_nx, ferr_nx;
    logic                 rx_meta, rx_s;

    // Two-flop synchronizer; both flops reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            dout      <= '0;
            dout_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            shreg     <= shreg_nx;
            dout      <= dout_nx;
            dout_rdy  <= rdy_nx;
            frame_err <= ferr_nx;
        end
    end

    // Next-state logic. cnt only advances while timing a bit, and is cleared
    // on every state entry and every data sample, so it never exceeds FULL_M1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        dout_nx  = dout;
        rdy_nx   = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) begin
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nx = '0;
                    if (!rx_s) begin
                        state_nx = DATA;
                        idx_nx   = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nx        = '0;
                    shreg_nx[idx] = rx_s;
                    idx_nx        = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        dout_nx  = shreg;
                        rdy_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        // Bad stop bit: report once, then wait out any break.
                        ferr_nx  = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                cnt_nx = '0;
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // Status and debug views of the FSM.
    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// The driver serialises frames and pushes the expected outcome (good byte, or
// frame error with dout unchanged) into exp_q. A negedge monitor pops and
// compares whenever the DUT pulses dout_rdy or frame_err.
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] dout;
    logic       dout_rdy;
    logic       frame_err;
    logic       busy;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected pulses: bit 8 set = frame error, bits 7:0 = expected dout.
    logic [8:0] exp_q[$];
    int         t_q[$];
    logic [7:0] last_good;
    logic       prev_rdy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .dout      (dout),
        .dout_rdy  (dout_rdy),
        .frame_err (frame_err),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks. All assume entry at posedge+#1 and leave at posedge+#1.
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (stop) begin
            exp_q.push_back({1'b0, b});
            t_q.push_back(cyc + 1);
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every output pulse against the scoreboard head.
    always @(negedge clk) begin
        logic [8:0] e;
        int         lat;
        if (rst) begin
            prev_rdy = 1'b0;
        end else begin
            if (prev_rdy) check("rdy_width", {31'd0, dout_rdy}, 32'd0);
            if (dout_rdy || frame_err) begin
                check("rdy_err_excl", {31'd0, dout_rdy & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: rdy=%0b err=%0b dout=%0h, none expected",
                             dout_rdy, frame_err, dout);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, e[8]});
                    check("dout", {24'd0, dout}, {24'd0, e[7:0]});
                    if (dout_rdy && !e[8] && t_q.size() > 0) begin
                        lat = cyc - t_q.pop_front();
                        checks++;
                        if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
                            errors++;
                            $display("FAIL rdy_latency: got %0d expected %0d +-1", lat, LAT_NOM);
                        end
                    end
                end
            end
            prev_rdy = dout_rdy;
        end
    end

    // Stimulus sequence.
    initial begin
        int         n;
        logic [7:0] b;
        logic [9:0] f;
        rx        = 1'b1;
        rst       = 1'b1;
        last_good = 8'h00;
        prev_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_rdy", {31'd0, dout_rdy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        align();
        rst = 1'b0;
        idle(20);
        @(negedge clk);
        check("idle_after_rst", {31'd0, busy}, 32'd0);
        align();

        // Single good frame.
        send_frame(8'hA5, 1'b1);
        idle(10);
        @(negedge clk);
        check("busy_after_a5", {31'd0, busy}, 32'd0);
        align();

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(10);

        // Four-cycle glitch must be rejected and the FSM return to idle.
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("glitch_idle", {31'd0, busy}, 32'd0);
        align();
        idle(10);

        // Bad stop bit followed by a long break.
        send_frame(8'h3C, 1'b0);
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("busy_in_break", {31'd0, busy}, 32'd1);
        check("dout_in_break", {24'd0, dout}, 32'h55);
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("busy_after_break", {31'd0, busy}, 32'd0);
        align();
        idle(5);

        // Reset in the middle of data bit 4 aborts the frame silently.
        f = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            repeat ((i == 4) ? CPB / 2 : CPB) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_dout", {24'd0, dout}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        align();
        rst = 1'b0;
        idle(10);
        @(negedge clk);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        align();
        send_frame(8'h81, 1'b1);
        idle(5);
        send_frame(8'hC3, 1'b1);
        idle(5);

        // Randomised frames, gaps and occasional bad stop bits.
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                send_frame(b, 1'b0);
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1;
                idle($urandom_range(2, 10));
            end else begin
                send_frame(b, 1'b1);
                if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 20));
            end
        end
        idle(30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d left in queue expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per bit (100 MHz / 115200); legal values are even and >= 8.
REQ-002 Parameter DATA_BITS, fixed at 8; frame is 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
REQ-003 Port clk, input, 1, sole clock; all state on rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port rx, input, 1, asynchronous serial line, idle high.
REQ-006 Port dout, output, 8, last correctly received byte; held stable until the next good frame.
REQ-007 Port dout_rdy, output, 1, one-cycle pulse when dout is updated; feeds uart_ctl's receive path.
REQ-008 Port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-009 Port busy, output, 1, high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s = second flop); no other logic samples raw rx.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; a bit counter cnt, a bit index idx[2:0] and a shift register are held.
REQ-012 cnt SHALL be cleared on every state entry and on every data-bit sample.
REQ-013 IDLE: rx_s == 0 -> START.
REQ-014 START: at cnt == CLKS_PER_BIT/2-1, rx_s == 0 -> DATA with idx = 0, else -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: at cnt == CLKS_PER_BIT-1, shift rx_s into bit idx (LSB first), then idx++; after idx 7 is sampled -> STOP.
REQ-016 STOP: at cnt == CLKS_PER_BIT-1, rx_s == 1 -> dout <= shift register, dout_rdy = 1 for exactly one cycle, -> IDLE.
REQ-017 STOP: at cnt == CLKS_PER_BIT-1, rx_s == 0 -> frame_err = 1 for exactly one cycle, dout unchanged, no dout_rdy, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s == 1, then -> IDLE; a break condition (rx held low) SHALL produce exactly one frame_err.
REQ-019 dout_rdy and frame_err SHALL never be high in the same cycle.
REQ-020 dout_rdy SHALL occur 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+-1) cycles after the first clk edge at which rx is low.
REQ-021 A start bit arriving in the cycle after return to IDLE SHALL be accepted; back-to-back frames with no idle gap SHALL all be received.
REQ-022 No backpressure: the consumer SHALL capture dout on dout_rdy; a later good frame overwrites dout.
REQ-023 cnt width SHALL be clog2(CLKS_PER_BIT); cnt SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-024 On rst high, asynchronously: state = IDLE, dout = 8'h00, dout_rdy = 0, frame_err = 0, busy = 0, cnt = 0, idx = 0, both sync flops = 1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no output pulse; after release, the first full frame SHALL be received correctly.
REQ-026 Reset release SHALL NOT be interpreted as a start bit while rx is high.

Verification (CLKS_PER_BIT = 16)
REQ-027 Send 8'hA5 with a good stop bit -> one dout_rdy, dout = 8'hA5, frame_err never high, busy low afterwards.
REQ-028 Send 8'h00, 8'hFF and 8'h55 back-to-back with no idle gap -> three dout_rdy pulses, each 160 +-1 cycles apart, dout = 00, FF, 55 in order.
REQ-029 Pulse rx low for 4 cycles -> no dout_rdy, no frame_err, FSM back in IDLE within 10 cycles.
REQ-030 Send 8'h3C with the stop bit low, then hold rx low for 400 cycles -> exactly one frame_err, dout keeps its previous value, busy stays high until rx rises.
REQ-031 Assert rst during data bit 4 of a frame, release, then send 8'h81 -> no pulse for the aborted frame, dout = 8'h00 after reset, then dout = 8'h81 with one dout_rdy.
REQ-032 Send 8'hC3 -> measure dout_rdy timing against REQ-020; dout_rdy width is exactly 1 cycle.
